muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit owning the architectural HI/LO registers. It sits beside the execute-stage ALU and consumes the same 6-bit `func` code and operand pair for mult/multu/div/divu/mthi/mtlo. It presents `busy` so the pipeline stalls issue while an operation is in flight. mfhi/mflo are served by reading the `hi`/`lo` outputs.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request valid this cycle; sampled only when `busy`=0.
- `func` in 6: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011; all other codes are no-ops.
- `in0` in 32: rs operand (dividend / multiplicand / mthi-mtlo source).
- `in1` in 32: rt operand (divisor / multiplier).
- `busy` out 1: iteration in progress; upstream must hold issue.
- `done` out 1: one-cycle pulse when a mult/div result lands in HI/LO.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. `busy` = (state != IDLE).
- IDLE + `start`:
  - mult/multu → MUL, count=0.
  - div/divu → DIV, count=0.
  - mthi: `hi`←`in0` at the next edge; stays IDLE; no `busy`, no `done`.
  - mtlo: `lo`←`in0` at the next edge; same handshake rules as mthi.
  - Other codes are ignored.
- Accept latches operand magnitudes plus sign flags:
  - Signed ops: absolute values; flags = operand MSBs.
  - Unsigned ops: raw values; flags = 0.
- MUL: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle. After 32 iterations → FIX.
- DIV: restoring shift-subtract over a 32-bit remainder/quotient pair, one quotient bit per cycle. After 32 iterations → FIX.
- FIX: applies sign correction, writes HI/LO, pulses `done`, → IDLE.
  - mult: {hi,lo} = product, negated if the sign flags differ.
  - div: quotient negated if the sign flags differ; remainder takes the dividend's sign. `lo`=quotient, `hi`=remainder.
- Divide by zero (any signedness): no trap; full latency; `lo`=32'hFFFFFFFF, `hi`=`in0` as latched.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: `lo`=32'h80000000, `hi`=0.
- HI/LO are not disturbed during iteration. Intermediate values live in private registers; HI/LO change only in FIX or on mthi/mtlo.
- `start` while `busy`=1: ignored entirely (no queueing).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0, internal accumulators=0.
- mult/div latency, with the accepting edge as E0:
  - `busy` high after E0 through E33 (33 cycles).
  - Iterations run on edges E1..E32.
  - FIX commits at E33; new `hi`/`lo` and `done`=1 are visible in the cycle after E33, when `busy` is already 0.
- Back-to-back issue: a new `start` is accepted in the same cycle `done` is high.
- mthi/mtlo latency: 1 edge. They may be issued in the cycle immediately after another accept completes.
- `rst` asserted mid-operation: all state returns to reset values immediately. The partial result is discarded, and HI/LO read 0.
- `done` is never high for two consecutive cycles.

## Configuration
- `MULDIV_DIV_EN` defined: div/divu are supported as above.
- `MULDIV_DIV_EN` undefined:
  - DIV state and divider datapath are removed.
  - div/divu are treated as no-ops: no `busy`, no `done`, HI/LO unchanged.
  - Multiply behaviour and all timing are unchanged.

## Structure
- `muldiv_pkg` holds the func code constants shared with the ALU, the state enum (IDLE/MUL/DIV/FIX), and the iteration count constant 32.
- One sub-module is natural: `muldiv_step`, a combinational single-iteration datapath. It performs either conditional add-shift (MUL) or trial-subtract-shift (DIV), selected by a mode bit, and is instantiated once.
- Sign correction and special-case overrides stay in `muldiv_unit`.

## Test plan
- mult, `in0`=-3 (32'hFFFFFFFD), `in1`=7 → `busy` 33 cycles, then `done`; `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB.
- multu, `in0`=`in1`=32'hFFFFFFFF → `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- div, `in0`=-7, `in1`=2 → `lo`=32'hFFFFFFFD (-3), `hi`=32'hFFFFFFFF (-1).
- divu, `in1`=0, `in0`=32'h1234 → `lo`=32'hFFFFFFFF, `hi`=32'h1234.
- Signed overflow: div, `in0`=32'h80000000, `in1`=32'hFFFFFFFF → `lo`=32'h80000000, `hi`=0.
- mthi 5 then mtlo 9 on consecutive cycles → `hi`=5, `lo`=9 with no `busy`/`done`.
- `start` mult while busy → ignored.
- `rst` at iteration 10 → `busy`=0 immediately, `hi`=`lo`=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide unit: the 6-bit func codes the
// ALU decodes alongside this unit, the sequencer state encoding, the
// iteration count, and a small absolute-value helper.
// Optional feature macro: MULDIV_DIV_EN (enables div/divu support).
package muldiv_pkg;

   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;
   localparam logic [5:0] FUNC_MTHI  = 6'b010001;
   localparam logic [5:0] FUNC_MTLO  = 6'b010011;

   // One result bit per iteration, 32 iterations per operation.
   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   // Two's-complement magnitude; 32'h80000000 maps to itself, which is the
   // correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// Combinational single-iteration datapath shared by multiply and divide.
// Optional feature macro: MULDIV_DIV_EN (divide path present only when set).
// Ports:
//   i_mode  : 0 = multiply add-shift, 1 = divide trial-subtract-shift
//   i_acc   : 64-bit working register before the iteration
//             MUL: {partial product high, remaining multiplier bits}
//             DIV: {partial remainder, remaining dividend / quotient bits}
//   i_opnd  : multiplicand (MUL) or divisor (DIV) magnitude
//   o_acc   : working register after the iteration
module muldiv_step (
   input  logic        i_mode,
   input  logic [63:0] i_acc,
   input  logic [31:0] i_opnd,
   output logic [63:0] o_acc
);

   // Multiply: add the multiplicand into the upper half when the current
   // multiplier bit (LSB) is set, then shift the whole 65-bit value right.
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_acc;

   assign w_mul_sum = {1'b0, i_acc[63:32]} + {1'b0, (i_acc[0] ? i_opnd : 32'd0)};
   assign w_mul_acc = {w_mul_sum, i_acc[31:1]};

`ifdef MULDIV_DIV_EN
   // Divide: shift the remainder/dividend pair left, try subtracting the
   // divisor from the 33-bit shifted remainder, keep it if non-negative and
   // shift the resulting quotient bit into the LSB.
   logic [64:0] w_shl;
   logic [32:0] w_trial;
   logic [63:0] w_div_acc;

   assign w_shl     = {i_acc, 1'b0};
   assign w_trial   = w_shl[64:32] - {1'b0, i_opnd};
   assign w_div_acc = w_trial[32] ? {w_shl[63:32], i_acc[30:0], 1'b0}
                                  : {w_trial[31:0], i_acc[30:0], 1'b1};

   assign o_acc = i_mode ? w_div_acc : w_mul_acc;
`else
   logic w_unused_mode;
   assign w_unused_mode = i_mode;
   assign o_acc         = w_mul_acc;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional feature macro: MULDIV_DIV_EN (div/divu supported when defined,
// treated as no-ops otherwise).
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request valid, sampled only while busy = 0
//   func  : 6-bit operation code (mult/multu/div/divu/mthi/mtlo)
//   in0   : rs operand (dividend / multiplicand / mthi-mtlo source)
//   in1   : rt operand (divisor / multiplier)
//   busy  : operation in flight, upstream holds issue
//   done  : one-cycle pulse when a mult/div result lands in HI/LO
//   hi    : HI register
//   lo    : LO register
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  func,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t             r_state;
   logic [CNT_W-1:0]   r_count;
   logic [63:0]        r_acc;
   logic [31:0]        r_opnd;
   logic               r_neg0;
   logic               r_neg1;
   logic               r_done;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
`ifdef MULDIV_DIV_EN
   logic               r_is_div;
`endif

   logic               w_mode;
   logic [63:0]        w_step_acc;
   logic [63:0]        w_prod_fix;

`ifdef MULDIV_DIV_EN
   assign w_mode = (r_state == ST_DIV);
`else
   assign w_mode = 1'b0;
`endif

   muldiv_step u_step (
      .i_mode (w_mode),
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .o_acc  (w_step_acc)
   );

   // Product is negated when exactly one signed operand was negative.
   assign w_prod_fix = (r_neg0 ^ r_neg1) ? (64'd0 - r_acc) : r_acc;

`ifdef MULDIV_DIV_EN
   logic [31:0] w_quot_fix;
   logic [31:0] w_rem_fix;
   logic        w_div_zero;

   // Remainder follows the dividend's sign. For a zero divisor the restoring
   // loop leaves |in0| in the remainder, so this also restores hi = in0.
   assign w_quot_fix = (r_neg0 ^ r_neg1) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
   assign w_rem_fix  = r_neg0 ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
   assign w_div_zero = (r_opnd == 32'd0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_neg0   <= 1'b0;
         r_neg1   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
`ifdef MULDIV_DIV_EN
         r_is_div <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  case (func)
                     FUNC_MULT: begin
                        r_state  <= ST_MUL;
                        r_count  <= '0;
                        r_opnd   <= abs32(in0);
                        r_acc    <= {32'd0, abs32(in1)};
                        r_neg0   <= in0[31];
                        r_neg1   <= in1[31];
`ifdef MULDIV_DIV_EN
                        r_is_div <= 1'b0;
`endif
                     end
                     FUNC_MULTU: begin
                        r_state  <= ST_MUL;
                        r_count  <= '0;
                        r_opnd   <= in0;
                        r_acc    <= {32'd0, in1};
                        r_neg0   <= 1'b0;
                        r_neg1   <= 1'b0;
`ifdef MULDIV_DIV_EN
                        r_is_div <= 1'b0;
`endif
                     end
`ifdef MULDIV_DIV_EN
                     FUNC_DIV: begin
                        r_state  <= ST_DIV;
                        r_count  <= '0;
                        r_opnd   <= abs32(in1);
                        r_acc    <= {32'd0, abs32(in0)};
                        r_neg0   <= in0[31];
                        r_neg1   <= in1[31];
                        r_is_div <= 1'b1;
                     end
                     FUNC_DIVU: begin
                        r_state  <= ST_DIV;
                        r_count  <= '0;
                        r_opnd   <= in1;
                        r_acc    <= {32'd0, in0};
                        r_neg0   <= 1'b0;
                        r_neg1   <= 1'b0;
                        r_is_div <= 1'b1;
                     end
`endif
                     FUNC_MTHI: r_hi <= in0;
                     FUNC_MTLO: r_lo <= in0;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               r_acc   <= w_step_acc;
               r_count <= r_count + 1'b1;
               if (r_count == CNT_W'(ITER_COUNT - 1)) r_state <= ST_FIX;
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
               r_acc   <= w_step_acc;
               r_count <= r_count + 1'b1;
               if (r_count == CNT_W'(ITER_COUNT - 1)) r_state <= ST_FIX;
            end
`endif
            ST_FIX: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
`ifdef MULDIV_DIV_EN
               if (r_is_div) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_div_zero ? 32'hFFFF_FFFF : w_quot_fix;
               end else begin
                  r_hi <= w_prod_fix[63:32];
                  r_lo <= w_prod_fix[31:0];
               end
`else
               r_hi <= w_prod_fix[63:32];
               r_lo <= w_prod_fix[31:0];
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: expected HI/LO values are queued when
// an operation is issued and compared when done pulses.
// Optional feature macro: MULDIV_DIV_EN (selects div expectations).
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  func;
   logic [31:0] in0;
   logic [31:0] in1;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string       tag;
      logic [63:0] hilo;
   } exp_t;

   exp_t sb_q[$];
   logic prev_done = 1'b0;

   muldiv_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .func  (func),
      .in0   (in0),
      .in1   (in1),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference results computed with native wide arithmetic; returns {hi, lo}.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb;
      int     ia, ib;
      logic [63:0] r;
      r = 64'd0;
      case (f)
         FUNC_MULT: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            r  = 64'(sa * sb);
         end
         FUNC_MULTU: r = {32'd0, a} * {32'd0, b};
         FUNC_DIV: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else begin
               ia = $signed(a);
               ib = $signed(b);
               r  = {32'(ia % ib), 32'(ia / ib)};
            end
         end
         FUNC_DIVU: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   function automatic bit is_long(input logic [5:0] f);
`ifdef MULDIV_DIV_EN
      return (f == FUNC_MULT || f == FUNC_MULTU || f == FUNC_DIV || f == FUNC_DIVU);
`else
      return (f == FUNC_MULT || f == FUNC_MULTU);
`endif
   endfunction

   // Result monitor: pops the scoreboard whenever done pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (prev_done) check_val("done_twice", 64'd1, 64'd0);
            if (sb_q.size() == 0) begin
               check_val("done_unexpected", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_val(e.tag, {hi, lo}, e.hilo);
               $display("[TB] %s: hi=%h lo=%h", e.tag, hi, lo);
            end
         end
         prev_done <= done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   // Issue one op at the current cycle (called #1 after a posedge).
   // inject_at >= 0: drive a second mult while busy at that cycle.
   // abort_at  >= 0: assert rst at that cycle and check the reset state.
   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int inject_at, input int abort_at);
      int          n;
      logic [63:0] old_hilo;
      exp_t        e;
      old_hilo = {hi, lo};
      start = 1'b1;
      func  = f;
      in0   = a;
      in1   = b;
      if (is_long(f)) begin
         e.tag  = tag;
         e.hilo = model(f, a, b);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!is_long(f)) begin
         check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
         repeat (2) @(posedge clk);
         #1;
         check_val({tag, "_hilo_kept"}, {hi, lo}, old_hilo);
         return;
      end
      n = 0;
      while (busy && n < 100) begin
         if (n == inject_at) begin
            start = 1'b1;
            func  = FUNC_MULT;
            in0   = 32'h0000_0BAD;
            in1   = 32'h0000_0777;
         end else begin
            start = 1'b0;
         end
         if (n == abort_at) begin
            start = 1'b0;
            rst   = 1'b1;
            #1;
            check_val({tag, "_rst_busy"}, {63'd0, busy}, 64'd0);
            check_val({tag, "_rst_hilo"}, {hi, lo}, 64'd0);
            sb_q.delete();
            $display("[TB] %s: reset at iteration %0d", tag, n);
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      check_val({tag, "_busy_cycles"}, 64'(n), 64'd33);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      func  = 6'd0;
      in0   = 32'd0;
      in1   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_done", {63'd0, done}, 64'd0);
      check_val("rst_hilo", {hi, lo}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("mult_neg3x7",  FUNC_MULT,  32'hFFFF_FFFD, 32'd7,        -1, -1);
      run_op("multu_max",    FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
      run_op("div_neg7by2",  FUNC_DIV,   32'hFFFF_FFF9, 32'd2,        -1, -1);
      run_op("divu_by0",     FUNC_DIVU,  32'h0000_1234, 32'd0,        -1, -1);
      run_op("div_ovf",      FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      run_op("div_neg_by0",  FUNC_DIV,   32'hFFFF_FFFB, 32'd0,        -1, -1);

      for (int i = 0; i < 6; i++) begin
         logic [5:0]  f;
         logic [31:0] a, b;
         case (i % 4)
            0: f = FUNC_MULT;
            1: f = FUNC_MULTU;
            2: f = FUNC_DIV;
            default: f = FUNC_DIVU;
         endcase
         a = $urandom;
         b = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
         run_op($sformatf("rand%0d", i), f, a, b, -1, -1);
      end

      // mthi then mtlo on consecutive cycles, issued right in the done cycle
      // of a preceding multiply.
      run_op("mult_pre_mt", FUNC_MULT, 32'd100, 32'hFFFF_FFFF, -1, -1);
      start = 1'b1;
      func  = FUNC_MTHI;
      in0   = 32'd5;
      @(posedge clk);
      #1;
      check_val("mthi_busy", {63'd0, busy}, 64'd0);
      func = FUNC_MTLO;
      in0  = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val("mtlo_busy", {63'd0, busy}, 64'd0);
      check_val("mthi_mtlo", {hi, lo}, {32'd5, 32'd9});
      $display("[TB] mthi_mtlo: hi=%h lo=%h", hi, lo);
      repeat (2) @(posedge clk);
      #1;

      run_op("mult_ignore", FUNC_MULT, 32'd12345, 32'hFFFF_FFF7, 5, -1);
      run_op("mult_rst", FUNC_MULT, 32'h00AB_CDEF, 32'h0000_1234, -1, 10);
      repeat (40) @(posedge clk);
      #1;
      check_val("post_rst_busy", {63'd0, busy}, 64'd0);
      check_val("post_rst_hilo", {hi, lo}, 64'd0);

      run_op("mult_recover", FUNC_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, -1);
      repeat (3) @(posedge clk);
      #1;
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
